// File: rtl/riscv_div_pkg.sv
// riscv_div_pkg: opcode constants and FSM state type for the divider front-end
package riscv_div_pkg;
  localparam logic [1:0] DIVU = 2'd0;
  localparam logic [1:0] DIV  = 2'd1;
  localparam logic [1:0] REMU = 2'd2;
  localparam logic [1:0] REM  = 2'd3;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, DRAIN} divState_t;
endpackage

// File: rtl/riscv_div_norm.sv
// riscv_div_norm: leading-bit count and left-justification of a divisor
// Signed mode counts leading copies of the sign bit minus one so the sign bit survives the shift.
module riscv_div_norm #(
  parameter int C_WIDTH     = 32,
  parameter int C_LOG_WIDTH = 6
) (
  input  logic [C_WIDTH-1:0]     Op_DI,
  input  logic                   Signed_SI,
  output logic [C_LOG_WIDTH-1:0] Shift_DO,
  output logic [C_WIDTH-1:0]     Norm_DO
);
  logic [C_LOG_WIDTH-1:0] cnt;
  logic                   run;
  always_comb begin
    cnt = '0;
    run = 1'b1;
    for (int i = C_WIDTH-1; i >= 0; i--) begin
      run = run & (Op_DI[i] == (Signed_SI & Op_DI[C_WIDTH-1]));
      cnt = cnt + C_LOG_WIDTH'(run);
    end
  end
  assign Shift_DO = Signed_SI ? cnt - C_LOG_WIDTH'(1) : cnt;
  assign Norm_DO  = Op_DI << Shift_DO;
endmodule

// File: rtl/riscv_div_frontend.sv
// riscv_div_frontend: issue/return sequencing for the serial divider
// Resolves divide-by-zero and signed overflow locally and drains flushed divides.
module riscv_div_frontend
  import riscv_div_pkg::*;
#(
  parameter int C_WIDTH     = 32,
  parameter int C_LOG_WIDTH = 6
) (
  input  logic                   Clk_CI,
  input  logic                   Rst_RBI,
  input  logic                   ReqVld_SI,
  output logic                   ReqRdy_SO,
  input  logic [C_WIDTH-1:0]     ReqOpA_DI,
  input  logic [C_WIDTH-1:0]     ReqOpB_DI,
  input  logic [1:0]             ReqOpCode_SI,
  input  logic                   Flush_SI,
  output logic                   RspVld_SO,
  input  logic                   RspRdy_SI,
  output logic [C_WIDTH-1:0]     RspRes_DO,
  output logic [C_WIDTH-1:0]     DivOpA_DO,
  output logic [C_WIDTH-1:0]     DivOpB_DO,
  output logic [C_LOG_WIDTH-1:0] DivOpBShift_DO,
  output logic                   DivOpBIsZero_SO,
  output logic                   DivOpBSign_SO,
  output logic [1:0]             DivOpCode_SO,
  output logic                   DivInVld_SO,
  output logic                   DivOutRdy_SO,
  input  logic                   DivOutVld_SI,
  input  logic [C_WIDTH-1:0]     DivRes_DI,
  output logic                   Busy_SO
);
  divState_t              state_SP, state_SN;
  logic [C_WIDTH-1:0]     opA_DP, opB_DP, res_DP, resFast_D, normB_D;
  logic [C_LOG_WIDTH-1:0] shift_DP, normShift_D;
  logic [1:0]             opCode_SP;
  logic                   bSign_SP, accept_S, isSigned_S, isRem_S, bZero_S, ovf_S, capture_S;

  riscv_div_norm #(.C_WIDTH(C_WIDTH), .C_LOG_WIDTH(C_LOG_WIDTH)) i_norm (
    .Op_DI    (ReqOpB_DI),
    .Signed_SI(isSigned_S),
    .Shift_DO (normShift_D),
    .Norm_DO  (normB_D)
  );

  assign isSigned_S = ReqOpCode_SI inside {DIV, REM};
  assign isRem_S    = ReqOpCode_SI inside {REMU, REM};
  assign bZero_S    = ReqOpB_DI == '0;
  assign ovf_S      = isSigned_S & (ReqOpA_DI == {1'b1, {(C_WIDTH-1){1'b0}}}) & (&ReqOpB_DI);
  // On overflow A is MIN, which is exactly the required div result
  assign resFast_D  = bZero_S ? (isRem_S ? ReqOpA_DI : '1) : (isRem_S ? '0 : ReqOpA_DI);
  assign accept_S   = ReqVld_SI & ReqRdy_SO;

  always_comb begin
    state_SN     = state_SP;
    ReqRdy_SO    = 1'b0;
    DivInVld_SO  = 1'b0;
    DivOutRdy_SO = 1'b0;
    RspVld_SO    = 1'b0;
    capture_S    = 1'b0;
    if (Rst_RBI) begin
      case (state_SP)
        IDLE: begin
          ReqRdy_SO = ~Flush_SI;
          if (ReqVld_SI & ~Flush_SI) state_SN = (bZero_S | ovf_S) ? RESP : ISSUE;
        end
        ISSUE: begin
          DivInVld_SO = DivOutVld_SI & ~Flush_SI;
          state_SN    = Flush_SI ? IDLE : DivInVld_SO ? WAIT : ISSUE;
        end
        // A flush coinciding with the result consumes it here so no second pulse is needed
        WAIT: begin
          DivOutRdy_SO = DivOutVld_SI;
          capture_S    = DivOutVld_SI & ~Flush_SI;
          state_SN     = DivOutVld_SI ? (Flush_SI ? IDLE : RESP) : (Flush_SI ? DRAIN : WAIT);
        end
        RESP: begin
          RspVld_SO = ~Flush_SI;
          if (Flush_SI | RspRdy_SI) state_SN = IDLE;
        end
        DRAIN: begin
          DivOutRdy_SO = DivOutVld_SI;
          if (DivOutVld_SI) state_SN = IDLE;
        end
        default: state_SN = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) begin
      state_SP  <= IDLE;
      opA_DP    <= '0;
      opB_DP    <= '0;
      shift_DP  <= '0;
      opCode_SP <= '0;
      bSign_SP  <= 1'b0;
      res_DP    <= '0;
    end else begin
      state_SP <= state_SN;
      if (accept_S) begin
        opA_DP    <= ReqOpA_DI;
        opB_DP    <= normB_D;
        shift_DP  <= normShift_D;
        opCode_SP <= ReqOpCode_SI;
        bSign_SP  <= isSigned_S & ReqOpB_DI[C_WIDTH-1];
        res_DP    <= resFast_D;
      end else if (capture_S) begin
        res_DP <= DivRes_DI;
      end
    end
  end

  assign RspRes_DO       = res_DP;
  assign DivOpA_DO       = opA_DP;
  assign DivOpB_DO       = opB_DP;
  assign DivOpBShift_DO  = shift_DP;
  assign DivOpBIsZero_SO = 1'b0;
  assign DivOpBSign_SO   = bSign_SP;
  assign DivOpCode_SO    = opCode_SP;
  assign Busy_SO         = state_SP != IDLE;
endmodule

// File: tb/tb_riscv_div_frontend.sv
// tb_riscv_div_frontend: directed vector bench with a behavioural serial divider
module tb_riscv_div_frontend;
  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [7:0]  lat;
  } vec_t;
  typedef enum logic [1:0] {M_IDLE, M_BUSY, M_DONE} mSt_t;

  logic        Clk_CI = 1'b0, Rst_RBI = 1'b0;
  logic        ReqVld_SI = 1'b0, ReqRdy_SO, Flush_SI = 1'b0, RspVld_SO, RspRdy_SI = 1'b0;
  logic [31:0] ReqOpA_DI = '0, ReqOpB_DI = '0, RspRes_DO, DivOpA_DO, DivOpB_DO, DivRes_DI;
  logic [1:0]  ReqOpCode_SI = '0, DivOpCode_SO;
  logic [5:0]  DivOpBShift_DO, mCnt;
  logic        DivOpBIsZero_SO, DivOpBSign_SO, DivInVld_SO, DivOutRdy_SO, DivOutVld_SI, Busy_SO;
  logic [31:0] mRes;
  mSt_t        mSt;
  int          nChk = 0, nErr = 0, nIn = 0, nOutRdy = 0, nRsp = 0;
  vec_t        vecs [14];

  riscv_div_frontend dut (
    .Clk_CI(Clk_CI), .Rst_RBI(Rst_RBI), .ReqVld_SI(ReqVld_SI), .ReqRdy_SO(ReqRdy_SO),
    .ReqOpA_DI(ReqOpA_DI), .ReqOpB_DI(ReqOpB_DI), .ReqOpCode_SI(ReqOpCode_SI), .Flush_SI(Flush_SI),
    .RspVld_SO(RspVld_SO), .RspRdy_SI(RspRdy_SI), .RspRes_DO(RspRes_DO),
    .DivOpA_DO(DivOpA_DO), .DivOpB_DO(DivOpB_DO), .DivOpBShift_DO(DivOpBShift_DO),
    .DivOpBIsZero_SO(DivOpBIsZero_SO), .DivOpBSign_SO(DivOpBSign_SO), .DivOpCode_SO(DivOpCode_SO),
    .DivInVld_SO(DivInVld_SO), .DivOutRdy_SO(DivOutRdy_SO), .DivOutVld_SI(DivOutVld_SI),
    .DivRes_DI(DivRes_DI), .Busy_SO(Busy_SO)
  );

  always #5 Clk_CI = ~Clk_CI;

  // Divider: recovers B from its normalised form and takes shift+1 busy cycles
  function automatic logic [31:0] divModel(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] bn, input logic [5:0] s);
    logic [31:0] b;
    b = op[0] ? 32'($signed(bn) >>> s) : bn >> s;
    case (op)
      2'd0:    return a / b;
      2'd1:    return 32'($signed(a) / $signed(b));
      2'd2:    return a % b;
      default: return 32'($signed(a) % $signed(b));
    endcase
  endfunction

  always @(posedge Clk_CI) begin
    if (!Rst_RBI) mSt <= M_IDLE;
    else case (mSt)
      M_IDLE: if (DivInVld_SO) begin
        mSt  <= M_BUSY;
        mCnt <= DivOpBShift_DO;
        mRes <= divModel(DivOpCode_SO, DivOpA_DO, DivOpB_DO, DivOpBShift_DO);
      end
      M_BUSY: if (mCnt == 6'd0) mSt <= M_DONE; else mCnt <= mCnt - 6'd1;
      M_DONE: if (DivOutRdy_SO) mSt <= M_IDLE;
      default: mSt <= M_IDLE;
    endcase
  end
  assign DivOutVld_SI = mSt != M_BUSY;
  assign DivRes_DI    = (mSt == M_DONE) ? mRes : 32'hDEADBEEF;

  always @(negedge Clk_CI) begin
    nIn     += int'(DivInVld_SO);
    nOutRdy += int'(DivOutRdy_SO);
    nRsp    += int'(RspVld_SO);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChk++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Starts at posedge+1 with the DUT idle; returns at posedge+1 after the response handshake
  task automatic runVec(input vec_t v, input int hold);
    int lat, in0, or0;
    logic got;
    ReqVld_SI = 1'b1; ReqOpCode_SI = v.op; ReqOpA_DI = v.a; ReqOpB_DI = v.b;
    in0 = nIn; or0 = nOutRdy;
    @(negedge Clk_CI);
    check("req_rdy", 32'(ReqRdy_SO), 32'd1);
    @(posedge Clk_CI); #1;
    ReqVld_SI = 1'b0;
    lat = 0; got = 1'b0;
    while (!got && lat < 100) begin
      @(negedge Clk_CI);
      lat++;
      if (RspVld_SO) got = 1'b1;
      else begin @(posedge Clk_CI); #1; end
    end
    check("rsp_seen", 32'(got), 32'd1);
    check("latency", 32'(lat), 32'(v.lat));
    check("result", RspRes_DO, v.res);
    check("in_vld_pulses", 32'(nIn - in0), (v.lat > 8'd1) ? 32'd1 : 32'd0);
    check("out_rdy_pulses", 32'(nOutRdy - or0), (v.lat > 8'd1) ? 32'd1 : 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(posedge Clk_CI); #1;
      @(negedge Clk_CI);
      check("stall_vld", 32'(RspVld_SO), 32'd1);
      check("stall_res", RspRes_DO, v.res);
      check("stall_req_rdy", 32'(ReqRdy_SO), 32'd0);
    end
    RspRdy_SI = 1'b1;
    @(posedge Clk_CI); #1;
    RspRdy_SI = 1'b0;
  endtask

  initial begin
    int n, in0, or0, rs0;
    vecs[0]  = '{2'd0, 32'd100,        32'd7,          32'd14,         8'd33};
    vecs[1]  = '{2'd2, 32'd100,        32'd7,          32'd2,          8'd33};
    vecs[2]  = '{2'd1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   8'd33};
    vecs[3]  = '{2'd3, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   8'd33};
    vecs[4]  = '{2'd1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   8'd34};
    vecs[5]  = '{2'd1, 32'd5,          32'd0,          32'hFFFFFFFF,   8'd1};
    vecs[6]  = '{2'd2, 32'd5,          32'd0,          32'd5,          8'd1};
    vecs[7]  = '{2'd1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   8'd1};
    vecs[8]  = '{2'd3, 32'h80000000,   32'hFFFFFFFF,   32'd0,          8'd1};
    vecs[9]  = '{2'd0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   8'd35};
    vecs[10] = '{2'd2, 32'd1,          32'h80000000,   32'd1,          8'd4};
    vecs[11] = '{2'd0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          8'd4};
    vecs[12] = '{2'd0, 32'd0,          32'd5,          32'd0,          8'd33};
    vecs[13] = '{2'd1, 32'h80000000,   32'd1,          32'h80000000,   8'd34};

    repeat (3) @(posedge Clk_CI);
    #1 ReqVld_SI = 1'b1;
    @(negedge Clk_CI);
    check("rst_req_rdy", 32'(ReqRdy_SO), 32'd0);
    check("rst_rsp_vld", 32'(RspVld_SO), 32'd0);
    check("rst_in_vld", 32'(DivInVld_SO), 32'd0);
    check("rst_out_rdy", 32'(DivOutRdy_SO), 32'd0);
    check("rst_busy", 32'(Busy_SO), 32'd0);
    check("rst_res", RspRes_DO, 32'd0);
    @(posedge Clk_CI); #1;
    Rst_RBI = 1'b1; ReqVld_SI = 1'b0;

    ReqVld_SI = 1'b1; Flush_SI = 1'b1; ReqOpA_DI = 32'd9; ReqOpB_DI = 32'd3;
    @(negedge Clk_CI);
    check("flush_idle_rdy", 32'(ReqRdy_SO), 32'd0);
    @(posedge Clk_CI); #1;
    ReqVld_SI = 1'b0; Flush_SI = 1'b0;
    @(negedge Clk_CI);
    check("flush_idle_busy", 32'(Busy_SO), 32'd0);
    @(posedge Clk_CI); #1;

    for (int i = 0; i < 14; i++) runVec(vecs[i], 0);

    runVec('{2'd0, 32'd100, 32'd7, 32'd14, 8'd33}, 5);
    runVec('{2'd0, 32'd10, 32'd3, 32'd3, 8'd34}, 0);

    in0 = nIn; or0 = nOutRdy; rs0 = nRsp;
    ReqVld_SI = 1'b1; ReqOpCode_SI = 2'd0; ReqOpA_DI = 32'd1000; ReqOpB_DI = 32'd3;
    @(posedge Clk_CI); #1;
    ReqVld_SI = 1'b0;
    repeat (2) @(posedge Clk_CI);
    #1 Flush_SI = 1'b1;
    @(posedge Clk_CI); #1;
    Flush_SI = 1'b0;
    n = 0;
    while (Busy_SO && n < 100) begin @(posedge Clk_CI); #1; n++; end
    check("drain_done", 32'(Busy_SO), 32'd0);
    check("drain_no_rsp", 32'(nRsp - rs0), 32'd0);
    check("drain_in_vld", 32'(nIn - in0), 32'd1);
    check("drain_out_rdy", 32'(nOutRdy - or0), 32'd1);
    runVec('{2'd0, 32'd10, 32'd3, 32'd3, 8'd34}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nChk, nErr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/riscv_div_frontend.md
# riscv_div_frontend

Issue/return front-end for the serial divider in the RISC-V ALU. It accepts a div/rem request from the ALU, normalises operand B into the divider's expected aligned form, and resolves RISC-V special cases (divide-by-zero, signed overflow) without launching the divider. It sequences the divider handshake, holds the result until the writeback side accepts it, and supports a pipeline flush that drains an in-flight divide cleanly.

## Interface
- C_WIDTH, 32, operand/result width
- C_LOG_WIDTH, 6, shift-count width; must equal $clog2(C_WIDTH+1)

- Clk_CI  in  1  clock; the block uses this single clock
- Rst_RBI  in  1  reset, synchronous and active-low
- ReqVld_SI  in  1  request valid
- ReqRdy_SO  out  1  request accepted when ReqVld_SI & ReqRdy_SO
- ReqOpA_DI  in  C_WIDTH  dividend
- ReqOpB_DI  in  C_WIDTH  divisor
- ReqOpCode_SI  in  2  0 divu, 1 div, 2 remu, 3 rem
- Flush_SI  in  1  abort the current operation
- RspVld_SO  out  1  result valid
- RspRdy_SI  in  1  result accepted
- RspRes_DO  out  C_WIDTH  result
- DivOpA_DO, DivOpB_DO  out  C_WIDTH  divider operands (B normalised)
- DivOpBShift_DO  out  C_LOG_WIDTH  divider iteration count minus one
- DivOpBIsZero_SO  out  1  constant 0; zero divisors are never issued
- DivOpBSign_SO  out  1  ReqOpCode[0] & B[C_WIDTH-1]
- DivOpCode_SO  out  2  registered opcode
- DivInVld_SO, DivOutRdy_SO  out  1  divider handshake
- DivOutVld_SI  in  1  divider valid; high while the divider is idle or finished
- DivRes_DI  in  C_WIDTH  divider result
- Busy_SO  out  1  state != IDLE

## Operation
- States: IDLE, ISSUE, WAIT, RESP, DRAIN.
- IDLE: ReqRdy_SO = ~Flush_SI. On accept, register A, B, opcode and the normalised B/shift, then classify the request:
  - B==0 → RESP. Result is all-ones for div/divu, A for rem/remu.
  - Signed op with A==MIN and B==all-ones → RESP. Result is MIN for div, 0 for rem.
  - Otherwise → ISSUE.
- Normalisation:
  - Unsigned: s = clz(B).
  - Signed: s = (count of leading bits equal to B[MSB]) − 1.
  - DivOpB_DO = B << s; DivOpBShift_DO = s.
- ISSUE: DivInVld_SO = DivOutVld_SI & ~Flush_SI. When it is asserted, go to WAIT. If DivOutVld_SI is low, hold in ISSUE.
- WAIT: on DivOutVld_SI, capture DivRes_DI into the result register, pulse DivOutRdy_SO for one cycle, and go to RESP.
- RESP: RspVld_SO = 1 with RspRes_DO held stable until RspRdy_SI, then go to IDLE. There is no IDLE bypass; a new request is accepted one cycle after the response completes.
- Flush:
  - In IDLE, flush blocks accept.
  - In ISSUE or RESP, flush suppresses DivInVld_SO / RspVld_SO and the block goes to IDLE next cycle.
  - In WAIT, the block goes to DRAIN. DRAIN waits for DivOutVld_SI, pulses DivOutRdy_SO, discards the result, and goes to IDLE. DRAIN emits no RspVld_SO.
  - Flush in DRAIN has no effect.
- Reset (Rst_RBI low at an edge): state → IDLE, result and operand registers → 0. While Rst_RBI is low, all handshake outputs (ReqRdy_SO, RspVld_SO, DivInVld_SO, DivOutRdy_SO) are 0. Reset mid-divide does not reset the divider from here; the divider shares Rst_RBI.

## Timing
- Accept at cycle 0.
- Fast path: RspVld_SO at cycle 1.
- Normal path (s = shift):
  - ISSUE at cycle 1 (DivInVld_SO high).
  - Divider iterates for cycles 2 .. s+2.
  - Divider FINISH at cycle s+3, where the result is captured.
  - RspVld_SO at cycle s+4.
- Each issued divide produces exactly one DivInVld_SO pulse and exactly one DivOutRdy_SO pulse.
- RspRes_DO is registered, with no combinational path from DivRes_DI.

## Structure
- Package riscv_div_pkg holds the opcode constants (DIVU/DIV/REMU/REM) and the state enum type.
- One combinational sub-module, riscv_div_norm, holds the leading-bit count and left shift. It outputs s and the shifted B and is shared with future ALU bit-count ops.
- The FSM, operand registers and result register live in the top module.

## Test plan
- divu 100/7 (clz(7)=29) → RspVld_SO at cycle 33 with 14; remu same operands → 2.
- div −7/2 → 0xFFFFFFFD; rem −7/2 → 0xFFFFFFFF; div 7/−2 → 0xFFFFFFFD.
- div 5/0 → 0xFFFFFFFF at cycle 1, with DivInVld_SO never asserted; remu 5/0 → 5.
- div 0x80000000/0xFFFFFFFF → 0x80000000 at cycle 1; rem same operands → 0.
- Flush two cycles after issue of 1000/3, then request divu 10/3:
  - no response for the flushed op;
  - DivOutRdy_SO pulses once in DRAIN;
  - the next response is 3.
- RspRdy_SI held low 5 cycles after RspVld_SO:
  - RspRes_DO stays stable;
  - ReqRdy_SO stays 0;
  - accept resumes the cycle after the handshake.
